arb8way16: RTL and testbench

- Round-robin arbiter and sequencer that shares one 16-bit output bus between 8 requesters (a..h).
- Drives the 3-bit select of a mux8way16 instance and sits between 8 producers and a single valid/ready consumer, such as a memory-write port or an output register.
- Grants one requester at a time, holds the grant until a handshake completes or the request is withdrawn, then rotates priority.

---
 rtl/arb8way16_if.sv | 24 ++
 rtl/arb8way16.sv | 131 +++++++++++++
 tb/tb_arb8way16.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/arb8way16_if.sv
// Shared bus between eight requesters, the round-robin arbiter and one valid/ready consumer.
// The requester/consumer side uses modport master; the arbiter uses modport slave.
interface arb8way16_if #(
  parameter int WIDTH = 16
);
  logic [7:0]       req;
  logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
  logic [7:0]       gnt;
  logic [7:0]       ack;
  logic [2:0]       sel;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output req, a, b, c, d, e, f, g, h, out_ready,
    input  gnt, ack, sel, y, out_valid
  );

  modport slave (
    input  req, a, b, c, d, e, f, g, h, out_ready,
    output gnt, ack, sel, y, out_valid
  );
endinterface

// File: rtl/arb8way16.sv
// 8-way round-robin arbiter driving a 16-bit mux onto a valid/ready consumer.
// Optional macro ARB_XFER_COUNT_EN adds a 16-bit completed-transfer counter output.
module arb8way16 #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  arb8way16_if.slave bus
`ifdef ARB_XFER_COUNT_EN
  ,
  output logic [15:0] xfer_count
`endif
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] last_q, last_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] win;
  logic       out_valid;
  logic       xfer;

  // First set request bit searching last+1 .. last+8 (mod 8).
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
    logic [2:0] w;
    logic [2:0] idx;
    logic       found;
    w     = last;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = last + 3'(i);
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [WIDTH-1:0] mux8way16(
    input logic [WIDTH-1:0] a, b, c, d, e, f, g, h,
    input logic [2:0]       s
  );
    logic [WIDTH-1:0] r;
    case (s)
      3'd0:    r = a;
      3'd1:    r = b;
      3'd2:    r = c;
      3'd3:    r = d;
      3'd4:    r = e;
      3'd5:    r = f;
      3'd6:    r = g;
      default: r = h;
    endcase
    return r;
  endfunction

  assign win       = rr_pick(bus.req, last_q);
  assign out_valid = (state_q == GRANT) && bus.req[sel_q];
  assign xfer      = out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          sel_d   = win;
          gnt_d   = 8'b1 << win;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A withdrawn request leaves the pointer alone so that requester keeps top priority.
        if (!bus.req[sel_q]) begin
          state_d = IDLE;
          gnt_d   = 8'h00;
        end else if (bus.out_ready) begin
          state_d = IDLE;
          gnt_d   = 8'h00;
          last_d  = sel_q;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      last_q  <= 3'd7;
      gnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
    end
  end

`ifdef ARB_XFER_COUNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 16'h0000;
    end else if (xfer) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign xfer_count = cnt_q;
`endif

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = out_valid;
  assign bus.ack       = gnt_q & {8{xfer}};
  assign bus.y         = out_valid ? mux8way16(bus.a, bus.b, bus.c, bus.d,
                                               bus.e, bus.f, bus.g, bus.h, sel_q)
                                   : '0;

endmodule

// File: tb/tb_arb8way16.sv
// Directed bench for arb8way16: rotation, sparse requests, stall, withdrawal, reset mid-grant.
module tb_arb8way16;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  arb8way16_if #(.WIDTH(16)) bus ();

`ifdef ARB_XFER_COUNT_EN
  logic [15:0] xfer_count;
`endif

  arb8way16 #(.WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave)
`ifdef ARB_XFER_COUNT_EN
    ,
    .xfer_count (xfer_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are then driven and outputs sampled mid-low-phase.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  int exp_sel[4];

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.req       = 8'h00;
    bus.out_ready = 1'b0;
    bus.a = 16'h0001; bus.b = 16'h0002; bus.c = 16'h0004; bus.d = 16'h0008;
    bus.e = 16'h0010; bus.f = 16'h0020; bus.g = 16'h0040; bus.h = 16'h0080;
    tick();
    tick();
    #1;
    check("rst_gnt", 32'(bus.gnt), 32'h00);
    check("rst_ack", 32'(bus.ack), 32'h00);
    check("rst_sel", 32'(bus.sel), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_y", 32'(bus.y), 32'h0000);

    // Full rotation with all requesters active.
    reset = 1'b0;
    bus.req = 8'hFF;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      #1;
      check("rot_sel", 32'(bus.sel), 32'(k % 8));
      check("rot_gnt", 32'(bus.gnt), 32'(8'b1 << (k % 8)));
      check("rot_valid", 32'(bus.out_valid), 32'd1);
      check("rot_y", 32'(bus.y), 32'(16'h0001 << (k % 8)));
      check("rot_ack", 32'(bus.ack), 32'(8'b1 << (k % 8)));
      tick();
      #1;
      check("rot_idle_valid", 32'(bus.out_valid), 32'd0);
      check("rot_idle_gnt", 32'(bus.gnt), 32'h00);
    end

    // Only requesters 2 and 5.
    bus.req = 8'b0010_0100;
    exp_sel[0] = 2; exp_sel[1] = 5; exp_sel[2] = 2; exp_sel[3] = 5;
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      check("sparse_sel", 32'(bus.sel), 32'(exp_sel[k]));
      check("sparse_gnt", 32'(bus.gnt), 32'(8'b1 << exp_sel[k]));
      tick();
    end

    // Stall on requester 3 for five cycles.
    bus.req = 8'h08;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      check("stall_gnt", 32'(bus.gnt), 32'h08);
      check("stall_y", 32'(bus.y), 32'h0008);
      check("stall_ack", 32'(bus.ack), 32'h00);
    end
    bus.out_ready = 1'b1;
    #1;
    check("stall_done_ack", 32'(bus.ack), 32'h08);
    tick();
    bus.req = 8'h00;
    #1;
    check("stall_after_valid", 32'(bus.out_valid), 32'd0);
    check("stall_after_ack", 32'(bus.ack), 32'h00);

    // Withdrawal by requester 4 keeps the pointer where it was.
    bus.req = 8'h10;
    bus.out_ready = 1'b0;
    tick();
    #1;
    check("wd_gnt", 32'(bus.gnt), 32'h10);
    check("wd_valid_before", 32'(bus.out_valid), 32'd1);
    bus.req = 8'h00;
    bus.out_ready = 1'b1;
    #1;
    check("wd_valid_drop", 32'(bus.out_valid), 32'd0);
    check("wd_ack", 32'(bus.ack), 32'h00);
    check("wd_y", 32'(bus.y), 32'h0000);
    tick();
    bus.req = 8'h11;
    tick();
    #1;
    check("wd_regrant_sel", 32'(bus.sel), 32'd4);
    check("wd_regrant_ack", 32'(bus.ack), 32'h10);
    tick();
    tick();
    #1;
    check("wd_next_sel", 32'(bus.sel), 32'd0);
    tick();
    bus.req = 8'h00;

    // Reset while a transfer is being offered.
    bus.req = 8'hFF;
    bus.out_ready = 1'b0;
    tick();
    #1;
    check("rstx_sel", 32'(bus.sel), 32'd1);
    bus.out_ready = 1'b1;
    reset = 1'b1;
    tick();
    #1;
    check("rstx_gnt", 32'(bus.gnt), 32'h00);
    check("rstx_valid", 32'(bus.out_valid), 32'd0);
    check("rstx_ack", 32'(bus.ack), 32'h00);
    check("rstx_y", 32'(bus.y), 32'h0000);
    reset = 1'b0;
    tick();
    #1;
    check("rstx_first_sel", 32'(bus.sel), 32'd0);
    check("rstx_first_gnt", 32'(bus.gnt), 32'h01);

`ifdef ARB_XFER_COUNT_EN
    reset = 1'b1;
    bus.req = 8'h00;
    tick();
    reset = 1'b0;
    #1;
    check("cnt_reset", 32'(xfer_count), 32'd0);
    bus.req = 8'h01;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      bus.req = 8'h02;
      bus.out_ready = 1'b0;
      tick();
      bus.req = 8'h00;
      tick();
    end
    #1;
    check("cnt_ten", 32'(xfer_count), 32'd10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
